// File: rtl/icache.sv
// ============================================================================
// Module  : icache
// Purpose : Direct-mapped, read-only instruction cache. Combinational hit
//           path to the fetch stage; full-line refill from instruction
//           memory over a request/valid word interface on a miss.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        invalidate_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t             state, state_nx;
  logic [LINES-1:0]   line_valid;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS];
  logic [31:0]        base_q;
  logic [OFF_W-1:0]   cnt_q;
  logic               drop_q;

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic [IDX_W-1:0]   fill_idx;
  logic               hit;
  logic               beat;
  logic               last_beat;
  logic               unused_byte_bits;

  assign off              = addr_i[IDX_LSB-1:2];
  assign idx              = addr_i[TAG_LSB-1:IDX_LSB];
  assign tag              = addr_i[31:TAG_LSB];
  assign fill_idx         = base_q[TAG_LSB-1:IDX_LSB];
  assign unused_byte_bits = ^addr_i[1:0];

  assign hit       = (state == IDLE) && line_valid[idx] && (tag_q[idx] == tag);
  assign beat      = mem_req_o && mem_valid_i;
  assign last_beat = beat && (cnt_q == LAST_WORD);

  // Next-state and output decode; an invalidate pulse masks any hit.
  always_comb begin
    state_nx   = state;
    valid_o    = hit && !invalidate_i;
    data_o     = valid_o ? data_q[idx][off] : 32'h0;
    mem_req_o  = (state == REFILL);
    mem_addr_o = mem_req_o ? (base_q | (32'(cnt_q) << 2)) : 32'h0;
    case (state)
      IDLE:    if (!hit && !invalidate_i) state_nx = REFILL;
      REFILL:  if (last_beat)             state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Refill bookkeeping: line base, beat counter, drop flag and valid bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q     <= 32'h0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      line_valid <= '0;
    end else begin
      if (state == IDLE && state_nx == REFILL) begin
        base_q <= {addr_i[31:IDX_LSB], {IDX_LSB{1'b0}}};
        cnt_q  <= '0;
        drop_q <= 1'b0;
      end
      if (beat) cnt_q <= cnt_q + 1'b1;
      if (state == REFILL) begin
        if (last_beat)         drop_q <= 1'b0;
        else if (invalidate_i) drop_q <= 1'b1;
      end
      // Invalidate wins over a completing refill in the same cycle.
      if (invalidate_i)              line_valid           <= '0;
      else if (last_beat && !drop_q) line_valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage; written only by refill beats.
  always_ff @(posedge clk_i) begin
    if (!rst_i && beat) begin
      data_q[fill_idx][cnt_q] <= mem_data_i;
      if (cnt_q == LAST_WORD) tag_q[fill_idx] <= base_q[31:TAG_LSB];
    end
  end

endmodule

`default_nettype wire
